escrita_registradores: RTL and testbench
========================================

// Module: escrita_registradores
// PURPOSE
//  Write-side front end for the 4x8-bit register bank: buffers writeback results
//  (ALU / load) in a small in-order queue and drains one per cycle into the bank's
//  write port (regWrite/regAlvo/data). Provides read-bypass lookups so the decode
//  stage sees queued-but-unwritten values. Sits between the writeback mux and the bank.
// PARAMETERS
//  DATA_W  8  width of register data
//  ADDR_W  2  register index width (4 registers)
//  DEPTH   4  queue entries (power of 2, >=2)
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  reset_n     in   1       synchronous reset, active low
//  wb_valid    in   1       writeback entry offered
//  wb_ready    out  1       queue can accept entry this cycle
//  wb_reg      in   ADDR_W  destination register of offered entry
//  wb_data     in   DATA_W  value of offered entry
//  hold        in   1       bank write port unavailable this cycle; no drain
//  flush       in   1       discard all queued entries (branch/BEQ squash)
//  regWrite    out  1       bank write enable
//  regAlvo     out  ADDR_W  bank write index
//  data        out  DATA_W  bank write value
//  rd_a        in   ADDR_W  bypass lookup index A (bank regAlvo read)
//  rd_b        in   ADDR_W  bypass lookup index B (bank regOpr read)
//  byp_hit_a   out  1       rd_a matches a queued entry
//  byp_val_a   out  DATA_W  youngest queued value for rd_a (0 when no hit)
//  byp_hit_b   out  1       as A, for rd_b
//  byp_val_b   out  DATA_W  as A, for rd_b
//  pending     out  3       number of queued entries (0..DEPTH)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): wr_ptr=rd_ptr=0, count=0, all entries invalid.
//    While reset_n=0: wb_ready=0, regWrite=0, byp_hit_*=0; data/regAlvo/byp_val_*=0.
//  - State: circular buffer of DEPTH {reg,data} + wr_ptr, rd_ptr, count. No FSM
//    beyond the occupancy counter.
//  - wb_ready = reset_n & (count != DEPTH) & !flush. Push on edge when
//    wb_valid & wb_ready: entry at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  - Drain: regWrite = (count!=0) & !hold & !flush & reset_n; regAlvo/data = head
//    entry (combinational from rd_ptr). Pop on the same edge the bank writes.
//  - Latency: entry pushed at edge N is written to bank at edge N+1 at earliest.
//    Entries never bypass the queue; order is strict FIFO.
//  - Push and pop same edge: count unchanged, both pointers advance.
//  - Full: wb_ready=0 even if a pop occurs this cycle (no pass-through at full).
//  - hold: queue frozen except pushes; outputs still present head, regWrite=0.
//  - flush: priority over push and pop; next edge count=0, rd_ptr=wr_ptr; no bank
//    write that cycle; offered entry is not accepted.
//  - Bypass: compare rd_a/rd_b to every valid entry; youngest (closest to wr_ptr)
//    match wins. Head entry counts as queued even in the cycle it is being written.
//    Combinational, no cycle delay. Does not look at wb_* inputs.
//  - pending = count; arithmetic width ADDR_W+1 bits, never exceeds DEPTH.
//  - Reset mid-operation discards all queued entries; no write issued.
// STRUCTURE
//  - Shared package/header: DATA_W, ADDR_W, register index constants
//    (R0..R3; BEQ fixed operands R2/R3) used by bank, decoder and this block.
//  - One sub-module: fila_escrita (parameterised FIFO storage + pointers + count);
//    bypass comparators and drain gating live in the top module.
// TESTING
//  1. Reset then push {r1,0x5A}: regWrite=1 next cycle with regAlvo=1, data=0x5A;
//     pending 1->0; bank r1=0x5A.
//  2. hold=1, push r0..r3 (0x10..0x13): 5th offer sees wb_ready=0, pending=4;
//     release hold -> four writes in order r0..r3 on consecutive cycles.
//  3. Queue {r2,0x11},{r2,0x22} under hold; rd_a=2 -> byp_hit_a=1, byp_val_a=0x22;
//     rd_b=3 -> byp_hit_b=0, byp_val_b=0.
//  4. pending=3, assert flush with wb_valid=1: no regWrite, entry rejected,
//     pending=0 next cycle; bank contents unchanged.
//  5. Steady stream push every cycle, hold=0: regWrite every cycle after first,
//     pending stays 1, pointers wrap past DEPTH without data loss (16 entries).
//  6. reset_n=0 with pending=2: no writes, wb_ready=0; after release pending=0.

Source files
------------

// File: rtl/escrita_registradores_pkg.sv
// Shared definitions for the register-bank write path.
// Holds the data/index widths, queue depth, register index constants
// (including the fixed BEQ operands) and the queued-entry record type.
package escrita_registradores_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  idx;
    reg_data_t value;
  } entry_t;

  localparam reg_idx_t R0 = 2'd0;
  localparam reg_idx_t R1 = 2'd1;
  localparam reg_idx_t R2 = 2'd2;
  localparam reg_idx_t R3 = 2'd3;

  // BEQ always compares these two registers.
  localparam reg_idx_t BEQ_OPR_A = R2;
  localparam reg_idx_t BEQ_OPR_B = R3;

endpackage

// File: rtl/escrita_registradores_if.sv
// Bus bundle between the writeback mux / decode stage and the write queue.
//   writeback : wb_valid, wb_ready, wb_reg, wb_data
//   control   : hold, flush
//   bank port : regWrite, regAlvo, data
//   bypass    : rd_a, rd_b -> byp_hit_a/b, byp_val_a/b
//   status    : pending
// slave is the queue side, master is the surrounding pipeline.
interface escrita_registradores_if;
  import escrita_registradores_pkg::*;

  logic             wb_valid;
  logic             wb_ready;
  reg_idx_t         wb_reg;
  reg_data_t        wb_data;
  logic             hold;
  logic             flush;
  logic             regWrite;
  reg_idx_t         regAlvo;
  reg_data_t        data;
  reg_idx_t         rd_a;
  reg_idx_t         rd_b;
  logic             byp_hit_a;
  reg_data_t        byp_val_a;
  logic             byp_hit_b;
  reg_data_t        byp_val_b;
  logic [CNT_W-1:0] pending;

  modport slave (
    input  wb_valid, wb_reg, wb_data, hold, flush, rd_a, rd_b,
    output wb_ready, regWrite, regAlvo, data,
           byp_hit_a, byp_val_a, byp_hit_b, byp_val_b, pending
  );

  modport master (
    output wb_valid, wb_reg, wb_data, hold, flush, rd_a, rd_b,
    input  wb_ready, regWrite, regAlvo, data,
           byp_hit_a, byp_val_a, byp_hit_b, byp_val_b, pending
  );

endinterface

// File: rtl/escrita_registradores_fila_escrita.sv
// fila_escrita: circular in-order storage for pending register writes.
// Ports:
//   clock_i, reset_n_i   clock, synchronous active-low reset
//   push_i, push_entry_i enqueue an entry at the write pointer
//   pop_i                retire the head entry
//   flush_i              drop every queued entry (wins over push/pop)
//   mem_o, rd_ptr_o      raw storage and head pointer for lookups
//   count_o              occupancy, 0..DEPTH
// Callers guarantee push_i only when not full and pop_i only when not empty.
module fila_escrita
  import escrita_registradores_pkg::*;
#(
  parameter int DEPTH_P = DEPTH
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          push_i,
  input  entry_t                        push_entry_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output entry_t [DEPTH_P-1:0]          mem_o,
  output logic [$clog2(DEPTH_P)-1:0]    rd_ptr_o,
  output logic [$clog2(DEPTH_P):0]      count_o
);

  localparam int PW = $clog2(DEPTH_P);

  entry_t [DEPTH_P-1:0] mem_q,    mem_d;
  logic   [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic   [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic   [PW:0]        count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Storage is left as is; an empty window is all that matters.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/escrita_registradores.sv
// escrita_registradores: write-side front end of the 4x8 register bank.
// Buffers writeback results in order and drains one per cycle into the
// bank write port; offers combinational bypass of queued values to decode.
// Ports:
//   clock, reset_n  clock, synchronous active-low reset
//   bus (slave)     writeback handshake, hold/flush, bank write port,
//                   bypass lookups and pending count
module escrita_registradores
  import escrita_registradores_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  escrita_registradores_if.slave   bus
);

  entry_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] rd_ptr;
  logic   [CNT_W-1:0] count;
  logic               push;
  logic               pop;
  entry_t             head;

  // No pass-through when full: a pop in the same cycle does not free a slot.
  assign bus.wb_ready = reset_n & (count != CNT_W'(DEPTH)) & ~bus.flush;
  assign push         = bus.wb_valid & bus.wb_ready;
  assign pop          = reset_n & (count != '0) & ~bus.hold & ~bus.flush;

  fila_escrita #(.DEPTH_P(DEPTH)) u_fila (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .push_i       (push),
    .push_entry_i ({bus.wb_reg, bus.wb_data}),
    .pop_i        (pop),
    .flush_i      (bus.flush),
    .mem_o        (mem),
    .rd_ptr_o     (rd_ptr),
    .count_o      (count)
  );

  assign head         = mem[rd_ptr];
  assign bus.regWrite = pop;
  assign bus.regAlvo  = reset_n ? head.idx   : '0;
  assign bus.data     = reset_n ? head.value : '0;
  assign bus.pending  = count;

  // Walk from oldest to youngest so the last match seen is the youngest.
  // The head is still a valid match in the cycle it is being written.
  always_comb begin
    bus.byp_hit_a = 1'b0;
    bus.byp_val_a = '0;
    bus.byp_hit_b = 1'b0;
    bus.byp_val_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (reset_n && (CNT_W'(k) < count)) begin
        if (mem[rd_ptr + PTR_W'(k)].idx == bus.rd_a) begin
          bus.byp_hit_a = 1'b1;
          bus.byp_val_a = mem[rd_ptr + PTR_W'(k)].value;
        end
        if (mem[rd_ptr + PTR_W'(k)].idx == bus.rd_b) begin
          bus.byp_hit_b = 1'b1;
          bus.byp_val_b = mem[rd_ptr + PTR_W'(k)].value;
        end
      end
    end
  end

endmodule

// File: tb/tb_escrita_registradores.sv
module tb_escrita_registradores;
  import escrita_registradores_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  entry_t exp_q[$];

  escrita_registradores_if bus();

  escrita_registradores dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every bank write must match the oldest expected entry.
  always @(negedge clock) begin
    if (bus.regWrite === 1'b1) begin
      if (reset_n !== 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL write_in_reset: regWrite=1 while reset_n=0");
      end else if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: regAlvo=%0d data=0x%0h, none expected",
                 bus.regAlvo, bus.data);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("wr_regAlvo", int'(bus.regAlvo), int'(e.idx));
        chk("wr_data",    int'(bus.data),    int'(e.value));
      end
    end
  end

  // Offer one entry for a single cycle; record it if it should be accepted.
  task automatic offer(input reg_idx_t idx, input reg_data_t val, input bit exp_rdy);
    entry_t e;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = idx;
    bus.wb_data  = val;
    @(negedge clock);
    chk("wb_ready", int'(bus.wb_ready), int'(exp_rdy));
    if (exp_rdy) begin
      e.idx = idx; e.value = val;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int cyc;
    cyc = 0;
    @(negedge clock);
    while (bus.pending !== '0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk(name, int'(bus.pending), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.hold = 1'b0; bus.flush = 1'b0; bus.rd_a = '0; bus.rd_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wb_ready",  int'(bus.wb_ready),  0);
    chk("rst_regWrite",  int'(bus.regWrite),  0);
    chk("rst_byp_hit_a", int'(bus.byp_hit_a), 0);
    chk("rst_regAlvo",   int'(bus.regAlvo),   0);
    chk("rst_data",      int'(bus.data),      0);
    chk("rst_pending",   int'(bus.pending),   0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // 1: single push, written the next cycle.
    offer(R1, 8'h5A, 1'b1);
    @(negedge clock);
    chk("t1_pending_1", int'(bus.pending),  1);
    chk("t1_regWrite",  int'(bus.regWrite), 1);
    @(negedge clock);
    chk("t1_pending_0", int'(bus.pending),  0);
    @(posedge clock); #1;

    // 2: fill under hold, 5th offer refused, then drain in order.
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) offer(reg_idx_t'(i), reg_data_t'(8'h10 + i), 1'b1);
    bus.wb_valid = 1'b1; bus.wb_reg = R0; bus.wb_data = 8'h99;
    @(negedge clock);
    chk("t2_full_ready", int'(bus.wb_ready), 0);
    chk("t2_pending_4",  int'(bus.pending),  4);
    chk("t2_hold_nowr",  int'(bus.regWrite), 0);
    @(posedge clock); #1;
    bus.wb_valid = 1'b0;
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t2_drain_wr", int'(bus.regWrite), 1);
    end
    @(negedge clock);
    chk("t2_drained", int'(bus.pending), 0);
    @(posedge clock); #1;

    // 3: bypass picks the youngest match.
    bus.hold = 1'b1;
    offer(R2, 8'h11, 1'b1);
    offer(R2, 8'h22, 1'b1);
    bus.rd_a = R2; bus.rd_b = R3;
    @(negedge clock);
    chk("t3_hit_a", int'(bus.byp_hit_a), 1);
    chk("t3_val_a", int'(bus.byp_val_a), 8'h22);
    chk("t3_hit_b", int'(bus.byp_hit_b), 0);
    chk("t3_val_b", int'(bus.byp_val_b), 0);
    @(posedge clock); #1;

    // 4: flush with three queued and an entry on offer.
    offer(R3, 8'h33, 1'b1);
    bus.hold = 1'b0;
    bus.flush = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_reg = R0; bus.wb_data = 8'h77;
    @(negedge clock);
    chk("t4_pending_3",  int'(bus.pending),  3);
    chk("t4_no_write",   int'(bus.regWrite), 0);
    chk("t4_no_accept",  int'(bus.wb_ready), 0);
    @(posedge clock); #1;
    exp_q.delete();
    bus.flush = 1'b0; bus.wb_valid = 1'b0;
    @(negedge clock);
    chk("t4_pending_0", int'(bus.pending),   0);
    chk("t4_hit_gone",  int'(bus.byp_hit_a), 0);
    @(posedge clock); #1;

    // 5: continuous stream of 16, pointers wrap several times.
    for (int i = 0; i < 16; i++) begin
      entry_t e;
      bus.wb_valid = 1'b1;
      bus.wb_reg   = reg_idx_t'(i % 4);
      bus.wb_data  = reg_data_t'(8'h40 + i);
      bus.rd_a     = reg_idx_t'((i + 3) % 4);
      bus.rd_b     = reg_idx_t'(i % 4);
      @(negedge clock);
      chk("t5_ready", int'(bus.wb_ready), 1);
      if (i > 0) begin
        chk("t5_pending",  int'(bus.pending),   1);
        chk("t5_regWrite", int'(bus.regWrite),  1);
        chk("t5_head_hit", int'(bus.byp_hit_a), 1);
        chk("t5_head_val", int'(bus.byp_val_a), 8'h40 + i - 1);
        chk("t5_no_wb_hit", int'(bus.byp_hit_b), 0);
      end else begin
        chk("t5_pending0", int'(bus.pending), 0);
      end
      e.idx = bus.wb_reg; e.value = bus.wb_data;
      exp_q.push_back(e);
      @(posedge clock); #1;
    end
    bus.wb_valid = 1'b0;
    wait_empty("t5_drain");

    // 6: reset with two entries queued.
    bus.hold = 1'b1;
    offer(R0, 8'hA1, 1'b1);
    offer(R1, 8'hA2, 1'b1);
    bus.hold = 1'b0;
    reset_n = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_reg = R2; bus.wb_data = 8'hA3;
    @(negedge clock);
    chk("t6_rst_ready", int'(bus.wb_ready), 0);
    chk("t6_rst_nowr",  int'(bus.regWrite), 0);
    chk("t6_rst_hit",   int'(bus.byp_hit_a), 0);
    @(posedge clock); #1;
    exp_q.delete();
    reset_n = 1'b1;
    bus.wb_valid = 1'b0;
    @(negedge clock);
    chk("t6_pending_0", int'(bus.pending),  0);
    chk("t6_no_write",  int'(bus.regWrite), 0);
    @(posedge clock); #1;

    repeat (2) @(posedge clock);
    chk("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
